cohort_mem_responder: RTL and testbench



---
 rtl/cohort_mem_responder.sv | 156 +++++++++++++++
 tb/tb_cohort_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cohort_mem_responder.sv
// Memory responder: queues load/store/atomic requests and services them one at a time
// against a local 64-bit word store, returning tagged responses in acceptance order.
module cohort_mem_responder #(
  parameter int DEPTH     = 4,
  parameter int MEM_WORDS = 256,
  parameter int LATENCY   = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [7:0]  req_mshrid,
  input  logic [39:0] req_address,
  input  logic [7:0]  req_write_mask,
  input  logic [63:0] req_data_0,
  output logic        resp_valid,
  output logic [7:0]  resp_mshrid,
  output logic [63:0] resp_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  localparam logic [1:0] T_LOAD  = 2'd0;
  localparam logic [1:0] T_STORE = 2'd1;
  localparam logic [1:0] T_ADD   = 2'd2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  mask);
    logic [63:0] r;
    for (int b = 0; b < 8; b++)
      r[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] next_word(input logic [1:0]  op,
                                            input logic [63:0] old_w,
                                            input logic [63:0] operand,
                                            input logic [7:0]  mask);
    case (op)
      T_LOAD:  return old_w;
      T_STORE: return merge_bytes(old_w, operand, mask);
      T_ADD:   return old_w + operand;
      default: return operand;
    endcase
  endfunction

  // Request queue (storage is data, left unreset)
  logic [1:0]       q_type   [DEPTH];
  logic [7:0]       q_mshrid [DEPTH];
  logic [IDX_W-1:0] q_idx    [DEPTH];
  logic [7:0]       q_mask   [DEPTH];
  logic [63:0]      q_data   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             full, empty, push, pop;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_address[2:0], req_address[39:3+IDX_W]};

  assign full      = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = !full && !rst;
  assign push      = req_valid && req_ready;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  assign pop = (state == IDLE) && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_type[wr_ptr[AW-1:0]]   <= req_type;
      q_mshrid[wr_ptr[AW-1:0]] <= req_mshrid;
      q_idx[wr_ptr[AW-1:0]]    <= req_address[3 +: IDX_W];
      q_mask[wr_ptr[AW-1:0]]   <= req_write_mask;
      q_data[wr_ptr[AW-1:0]]   <= req_data_0;
    end
  end

  // Stage p1: working registers loaded at pop
  logic [1:0]       type_p1;
  logic [7:0]       mshrid_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [7:0]       mask_p1;
  logic [63:0]      data_p1;

  always_ff @(posedge clk) begin
    if (pop) begin
      type_p1   <= q_type[rd_ptr[AW-1:0]];
      mshrid_p1 <= q_mshrid[rd_ptr[AW-1:0]];
      idx_p1    <= q_idx[rd_ptr[AW-1:0]];
      mask_p1   <= q_mask[rd_ptr[AW-1:0]];
      data_p1   <= q_data[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (!empty) begin
        state_nxt = WAIT;
        cnt_nxt   = LATENCY[CNT_W-1:0];
      end
      WAIT: if (cnt == '0) state_nxt = RESP;
            else           cnt_nxt   = cnt - CNT_W'(1);
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p2: read-modify-write of the addressed word, response driven from the old value
  logic [63:0] mem [MEM_WORDS];
  logic [63:0] old_p2;
  logic        vld_p2;

  assign old_p2 = mem[idx_p1];
  assign vld_p2 = (state == RESP);

  always_ff @(posedge clk) begin
    if (vld_p2) mem[idx_p1] <= next_word(type_p1, old_p2, data_p1, mask_p1);
  end

  assign resp_valid  = vld_p2;
  assign resp_mshrid = vld_p2 ? mshrid_p1 : 8'd0;
  assign resp_data   = (vld_p2 && type_p1 != T_STORE) ? old_p2 : 64'd0;

endmodule

// File: tb/tb_cohort_mem_responder.sv
// Scoreboard bench for cohort_mem_responder: a word-map model predicts every response at
// acceptance time; an independent negedge monitor pops and compares each resp_valid pulse.
module tb_cohort_mem_responder;

  localparam int DEPTH     = 4;
  localparam int MEM_WORDS = 256;
  localparam int LATENCY   = 3;
  localparam int IW        = $clog2(MEM_WORDS);

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [7:0]  req_mshrid;
  logic [39:0] req_address;
  logic [7:0]  req_write_mask;
  logic [63:0] req_data_0;
  logic        resp_valid;
  logic [7:0]  resp_mshrid;
  logic [63:0] resp_data;

  always #5 clk = ~clk;

  cohort_mem_responder #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_mshrid(req_mshrid), .req_address(req_address),
    .req_write_mask(req_write_mask), .req_data_0(req_data_0),
    .resp_valid(resp_valid), .resp_mshrid(resp_mshrid), .resp_data(resp_data)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct { logic [7:0] id; logic [63:0] data; } exp_t;
  exp_t        exp_q [$];
  logic [63:0] mdl [int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: requests complete in acceptance order, so predicting at accept time is exact.
  task automatic model_accept(input logic [1:0] t, input logic [7:0] id, input logic [39:0] a,
                              input logic [7:0] m, input logic [63:0] d);
    int          idx;
    logic [63:0] old_w, new_w;
    exp_t        e;
    idx   = int'(a[3 +: IW]);
    old_w = mdl.exists(idx) ? mdl[idx] : 64'hx;
    new_w = old_w;
    e.id  = id;
    case (t)
      2'd0: e.data = old_w;
      2'd1: begin
        e.data = 64'd0;
        for (int b = 0; b < 8; b++) if (m[b]) new_w[8*b +: 8] = d[8*b +: 8];
      end
      2'd2: begin e.data = old_w; new_w = old_w + d; end
      default: begin e.data = old_w; new_w = d; end
    endcase
    mdl[idx] = new_w;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] t, input logic [7:0] id, input logic [39:0] a,
                      input logic [7:0] m, input logic [63:0] d, output int stalls);
    req_type = t; req_mshrid = id; req_address = a; req_write_mask = m; req_data_0 = d;
    req_valid = 1'b1;
    stalls = 0;
    @(negedge clk);
    while (!req_ready && stalls < 500) begin
      @(negedge clk);
      stalls++;
    end
    if (!req_ready) begin
      chk("send_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      model_accept(t, id, a, m, d);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every response must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", {56'd0, resp_mshrid}, 64'hx);
        end else begin
          e = exp_q.pop_front();
          chk("resp_mshrid", {56'd0, resp_mshrid}, {56'd0, e.id});
          chk("resp_data", resp_data, e.data);
        end
      end
    end
  end

  initial begin
    int          st, n, first_stall, total_stall;
    logic [39:0] a;
    logic [1:0]  t;

    rst = 1'b1; req_valid = 1'b0; req_type = '0; req_mshrid = '0;
    req_address = '0; req_write_mask = '0; req_data_0 = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_resp_mshrid", {56'd0, resp_mshrid}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    rst = 1'b0;
    #1 chk("ready_after_release", {63'd0, req_ready}, 64'd1);
    @(posedge clk); #1;

    // Full store from idle, with exact latency, then read back
    send(2'd1, 8'd5, 40'h40, 8'hFF, 64'h1122334455667788, st);
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid && n < 50);
    chk("store_latency", 64'(n), 64'(LATENCY + 3));
    drain();
    send(2'd0, 8'd6, 40'h40, 8'h00, 64'h0, st); req_valid = 1'b0;
    drain();

    // Partial store merge
    send(2'd1, 8'd7, 40'h40, 8'h0F, 64'hAAAAAAAABBBBBBBB, st);
    send(2'd0, 8'd8, 40'h40, 8'h00, 64'h0, st); req_valid = 1'b0;
    drain();

    // Atomic add with wrap, then swap
    send(2'd1, 8'd9,  40'h40, 8'hFF, 64'hFFFFFFFFFFFFFFFF, st);
    send(2'd2, 8'd10, 40'h40, 8'h00, 64'd1, st);
    send(2'd0, 8'd11, 40'h40, 8'h00, 64'd0, st);
    send(2'd3, 8'd12, 40'h40, 8'h00, 64'd5, st);
    send(2'd0, 8'd13, 40'h40, 8'h00, 64'd0, st); req_valid = 1'b0;
    drain();

    // Ten back-to-back requests: queue fills after 4 queued + 1 in service
    first_stall = -1; total_stall = 0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send(2'd1, 8'(i), 40'(i * 8), 8'hFF, 64'hC0DE_0000_0000_0000 + 64'(i), st);
      else            send(2'd0, 8'(i), 40'((i - 1) * 8), 8'h00, 64'd0, st);
      if (st > 0 && first_stall < 0) first_stall = i;
      total_stall += st;
    end
    req_valid = 1'b0;
    chk("first_stalled_request", 64'(first_stall), 64'd5);
    chk("backpressure_seen", 64'(total_stall > 0), 64'd1);
    drain();

    // Aliasing: 0x800 and 0x0 share index 0
    send(2'd1, 8'd20, 40'h800, 8'hFF, 64'hDEADBEEFCAFEF00D, st);
    send(2'd0, 8'd21, 40'h0, 8'h00, 64'd0, st); req_valid = 1'b0;
    drain();

    // Randomized traffic over 8 words with random upper/lower address bits
    for (int i = 0; i < 8; i++) send(2'd1, 8'(100 + i), 40'(i * 8), 8'hFF, {$urandom, $urandom}, st);
    for (int i = 0; i < 80; i++) begin
      a = {$urandom, 8'h00};
      a[3 +: IW] = IW'($urandom_range(0, 7));
      a[2:0] = 3'($urandom_range(0, 7));
      t = 2'($urandom_range(0, 3));
      send(t, 8'($urandom), a, 8'($urandom), {$urandom, $urandom}, st);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 8)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    drain();

    // Reset with one request in WAIT and three queued
    for (int i = 0; i < 4; i++) send(2'd0, 8'(200 + i), 40'(i * 8), 8'h00, 64'd0, st);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    mdl.delete();
    #1;
    chk("midop_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("midop_rst_req_ready", {63'd0, req_ready}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    end
    rst = 1'b0;
    #1 chk("ready_after_midop_release", {63'd0, req_ready}, 64'd1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) n++;
    end
    chk("no_stale_resp", 64'(n), 64'd0);
    @(posedge clk); #1;

    // Normal service resumes after reset
    send(2'd1, 8'd30, 40'h18, 8'hFF, 64'h0123456789ABCDEF, st);
    send(2'd0, 8'd31, 40'h18, 8'h00, 64'd0, st); req_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
